// File: rtl/color_apb_pkg.sv
// Shared definitions for the colour-sensor APB register block: register
// offsets, field positions, the RGB sample type and the address decoder.
package color_apb_pkg;

  localparam logic [3:0] CTRL_OFS   = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] DATA_OFS   = 4'h8;
  localparam logic [3:0] THRESH_OFS = 4'hC;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int CTRL_CLR_BIT   = 2;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_CNT_LSB   = 4;
  localparam int ST_OVF_BIT   = 12;

  localparam int THRESH_W = 5;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_DATA,
    REG_THRESH,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [3:0] ofs, input logic upper_ok);
    reg_sel_e sel;
    if (!upper_ok) begin
      sel = REG_NONE;
    end else begin
      case (ofs)
        CTRL_OFS:   sel = REG_CTRL;
        STATUS_OFS: sel = REG_STATUS;
        DATA_OFS:   sel = REG_DATA;
        THRESH_OFS: sel = REG_THRESH;
        default:    sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic [4:0] count, input logic ovf);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[ST_EMPTY_BIT]            = empty;
    w[ST_FULL_BIT]             = full;
    w[ST_CNT_LSB +: THRESH_W]  = count;
    w[ST_OVF_BIT]              = ovf;
    return w;
  endfunction

endpackage

// File: rtl/color_apb_regs_if.sv
// APB3 bus bundle between the master and the colour-sensor register block.
interface apb_interface #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/color_sample_fifo.sv
// Synchronous RGB sample FIFO. A push into a full FIFO is accepted only when
// a pop retires an entry on the same edge; clear wins over push and pop.
module color_sample_fifo
  import color_apb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  rgb_t          wdata_i,
  output rgb_t          rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rgb_t          mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_o   = (count_q == CW'(0));
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rptr_q];
  assign do_pop_s  = pop_i & ~empty_o & ~clear_i;
  assign do_push_s = push_i & ~clear_i & (~full_o | do_pop_s);

  // Next pointer and occupancy; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = PW'(0);
      rptr_d  = PW'(0);
      count_d = CW'(0);
    end else begin
      if (do_push_s) begin
        wptr_d = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= PW'(0);
      rptr_q  <= PW'(0);
      count_q <= CW'(0);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Sample storage; contents are only observable through a valid read pointer.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/color_apb_regs.sv
// APB3 completer for the colour-sensor subsystem: control/status/threshold
// registers, a sample FIFO drained through DATA, and a level interrupt.
module color_apb_regs
  import color_apb_pkg::*;
#(
  parameter int APB_AW      = 32,
  parameter int APB_DW      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  apb_interface.slave apb,
  input  logic        sample_valid,
  input  logic [23:0] sample_rgb,
  output logic        sensor_en,
  output logic        irq
);

  localparam int         CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] WS_L    = 3'(WAIT_STATES);
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

  logic [2:0]          wcnt_q, wcnt_d;
  logic                en_q, en_d;
  logic                irq_en_q, irq_en_d;
  logic                ovf_q, ovf_d;
  logic                irq_q, irq_d;
  logic [THRESH_W-1:0] thresh_q, thresh_d;

  logic                access_s;
  logic                pready_s;
  logic                pslverr_s;
  logic [31:0]         prdata_s;
  logic                upper_ok_s;
  reg_sel_e            sel_s;
  logic                clear_s;
  logic                pop_s;
  logic                ovf_clr_s;
  logic                push_req_s;
  logic                drop_s;

  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CW-1:0]       fifo_count_s;
  logic [4:0]          count5_s;
  rgb_t                fifo_rdata_s;

  assign access_s    = apb.psel & apb.penable;
  assign pready_s    = access_s & (wcnt_q == WS_L);
  assign upper_ok_s  = ~|apb.paddr[APB_AW-1:4];
  assign sel_s       = decode_reg(apb.paddr[3:0], upper_ok_s);
  assign count5_s    = 5'(fifo_count_s);
  assign push_req_s  = sample_valid & en_q;
  assign drop_s      = push_req_s & fifo_full_s & ~pop_s & ~clear_s;

  assign apb.pready  = pready_s;
  assign apb.prdata  = prdata_s;
  assign apb.pslverr = pslverr_s;
  assign sensor_en   = en_q;
  assign irq         = irq_q;

  // Access-phase wait counter; restarts whenever a transfer ends or is dropped.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!apb.psel || pready_s) begin
      wcnt_d = 3'd0;
    end else if (access_s && (wcnt_q < WS_L)) begin
      wcnt_d = wcnt_q + 3'd1;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Register decode: read mux, error response and write side effects at completion.
  always_comb begin
    prdata_s  = 32'h0000_0000;
    pslverr_s = 1'b0;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    thresh_d  = thresh_q;
    clear_s   = 1'b0;
    pop_s     = 1'b0;
    ovf_clr_s = 1'b0;
    if (pready_s) begin
      case (sel_s)
        REG_CTRL: begin
          if (apb.pwrite) begin
            en_d     = apb.pwdata[CTRL_EN_BIT];
            irq_en_d = apb.pwdata[CTRL_IRQEN_BIT];
            clear_s  = apb.pwdata[CTRL_CLR_BIT];
          end else begin
            prdata_s[CTRL_EN_BIT]    = en_q;
            prdata_s[CTRL_IRQEN_BIT] = irq_en_q;
          end
        end
        REG_STATUS: begin
          if (apb.pwrite) begin
            ovf_clr_s = apb.pwdata[ST_OVF_BIT];
          end else begin
            prdata_s = pack_status(fifo_empty_s, fifo_full_s, count5_s, ovf_q);
          end
        end
        REG_DATA: begin
          if (apb.pwrite || fifo_empty_s) begin
            pslverr_s = 1'b1;
          end else begin
            prdata_s = {8'h00, fifo_rdata_s};
            pop_s    = 1'b1;
          end
        end
        REG_THRESH: begin
          if (apb.pwrite) begin
            if (apb.pwdata[THRESH_W-1:0] > DEPTH_L) begin
              thresh_d = DEPTH_L;
            end else begin
              thresh_d = apb.pwdata[THRESH_W-1:0];
            end
          end else begin
            prdata_s[THRESH_W-1:0] = thresh_q;
          end
        end
        default: begin
          pslverr_s = 1'b1;
        end
      endcase
    end else begin
      prdata_s  = 32'h0000_0000;
      pslverr_s = 1'b0;
    end
  end

  // Sticky overflow; a fresh drop on the clearing edge keeps it set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Interrupt level is computed from the current registered state.
  always_comb begin
    irq_d = irq_en_q & ((((count5_s >= thresh_q) & (thresh_q != 5'd0))) | ovf_q);
  end

  // Control and status state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q   <= 3'd0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      thresh_q <= 5'd1;
    end else begin
      wcnt_q   <= wcnt_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      thresh_q <= thresh_d;
    end
  end

  color_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req_s),
    .pop_i   (pop_s),
    .clear_i (clear_s),
    .wdata_i (rgb_t'(sample_rgb)),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

endmodule

// File: tb/tb_color_apb_regs.sv
// Directed plus randomized bench for color_apb_regs, checked against a
// register-level model built on a sample queue.
module tb_color_apb_regs;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_rgb = 24'h0;
  logic        sensor_en;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  apb_interface #(.AW(AW), .DW(DW)) bus ();

  color_apb_regs #(
    .APB_AW(AW), .APB_DW(DW), .FIFO_DEPTH(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apb          (bus),
    .sample_valid (sample_valid),
    .sample_rgb   (sample_rgb),
    .sensor_en    (sensor_en),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [23:0] mq[$];
  bit          m_en, m_irqen, m_ovf;
  int          m_thresh;

  function automatic void m_reset();
    mq.delete();
    m_en = 1'b0; m_irqen = 1'b0; m_ovf = 1'b0; m_thresh = 1;
  endfunction

  function automatic logic [31:0] m_irq();
    return {31'h0, m_irqen & (((mq.size() >= m_thresh) && (m_thresh != 0)) | m_ovf)};
  endfunction

  function automatic void m_sample(input logic [23:0] v);
    if (m_en) begin
      if (mq.size() < DEPTH) mq.push_back(v);
      else m_ovf = 1'b1;
    end
  endfunction

  // Model of one completed transfer (plus an optional sample on that same edge)
  function automatic void m_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                   input bit push, input logic [23:0] pv,
                                   output logic [31:0] rd, output logic [31:0] err);
    bit en_before = m_en;
    bit clr = 1'b0;
    rd = 32'h0; err = 32'h0;
    if (addr[31:4] != 28'h0) err = 32'h1;
    else begin
      case (addr[3:0])
        4'h0: if (wr) begin m_en = wd[0]; m_irqen = wd[1]; clr = wd[2]; end
              else rd = {30'h0, m_irqen, m_en};
        4'h4: if (wr) begin if (wd[12]) m_ovf = 1'b0; end
              else rd = (32'(m_ovf) << 12) | (32'(mq.size()) << 4)
                        | (32'(mq.size() == DEPTH) << 1) | 32'(mq.size() == 0);
        4'h8: if (wr || mq.size() == 0) err = 32'h1;
              else rd = {8'h00, mq.pop_front()};
        4'hC: if (wr) m_thresh = (wd[4:0] > DEPTH) ? DEPTH : int'(wd[4:0]);
              else rd = 32'(m_thresh);
        default: err = 32'h1;
      endcase
    end
    if (clr) mq.delete();
    if (push && en_before && !clr) begin
      if (mq.size() < DEPTH) mq.push_back(pv);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One APB transfer; returns read data, error flag and access cycles to pready
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input bit push, input logic [23:0] pv,
                      output logic [31:0] rd, output logic err, output int ncyc);
    int n = 0;
    bit done = 1'b0;
    rd = 32'h0; err = 1'b0; ncyc = 0;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    while (!done && n < 20) begin
      n++;
      @(negedge clk);
      if (bus.pready) begin
        rd = bus.prdata; err = bus.pslverr; ncyc = n; done = 1'b1;
        if (push) begin sample_valid = 1'b1; sample_rgb = pv; end
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    chk("xfer_done", {31'h0, done}, 32'h1);
  endtask

  task automatic acc(input string tag, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, input bit push, input logic [23:0] pv,
                     output logic [31:0] rd);
    logic [31:0] e_rd, e_err;
    logic        err;
    int          ncyc;
    m_access(wr, addr, wd, push, pv, e_rd, e_err);
    xfer(wr, addr, wd, push, pv, rd, err, ncyc);
    chk({tag, "_prdata"}, rd, e_rd);
    chk({tag, "_pslverr"}, {31'h0, err}, e_err);
    chk({tag, "_wait"}, 32'(ncyc), 32'(WS + 1));
  endtask

  task automatic push_sample(input logic [23:0] v);
    sample_valid = 1'b1; sample_rgb = v;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    m_sample(v);
  endtask

  task automatic chk_irq(input string tag);
    @(posedge clk); #1;
    chk(tag, {31'h0, irq}, m_irq());
    chk({tag, "_sensor_en"}, {31'h0, sensor_en}, {31'h0, m_en});
  endtask

  logic [31:0] rd;
  logic [23:0] nv;

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 32'h0; bus.pwdata = 32'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", {31'h0, bus.pready}, 32'h0);
    chk("rst_prdata", bus.prdata, 32'h0);
    chk("rst_pslverr", {31'h0, bus.pslverr}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_sensor_en", {31'h0, sensor_en}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset values of every register
    acc("rd_ctrl", 1'b0, 32'h0, 32'h0, 1'b0, 24'h0, rd);
    chk("rd_ctrl_const", rd, 32'h0);
    acc("rd_status", 1'b0, 32'h4, 32'h0, 1'b0, 24'h0, rd);
    chk("rd_status_const", rd, 32'h1);
    acc("rd_thresh", 1'b0, 32'hC, 32'h0, 1'b0, 24'h0, rd);
    chk("rd_thresh_const", rd, 32'h1);
    acc("rd_data_empty", 1'b0, 32'h8, 32'h0, 1'b0, 24'h0, rd);

    // Basic push/pop with interrupt latency
    acc("wr_ctrl", 1'b1, 32'h0, 32'h3, 1'b0, 24'h0, rd);
    push_sample(24'h112233);
    chk("irq_latency0", {31'h0, irq}, 32'h0);
    chk_irq("irq_after_push");
    push_sample(24'h445566);
    acc("pop1", 1'b0, 32'h8, 32'h0, 1'b0, 24'h0, rd);
    chk("pop1_const", rd, 32'h0011_2233);
    acc("pop2", 1'b0, 32'h8, 32'h0, 1'b0, 24'h0, rd);
    chk("pop2_const", rd, 32'h0044_5566);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    chk_irq("irq_after_pop");
    acc("status_empty", 1'b0, 32'h4, 32'h0, 1'b0, 24'h0, rd);

    // Overflow with level interrupt disabled
    acc("thresh0", 1'b1, 32'hC, 32'h0, 1'b0, 24'h0, rd);
    for (int i = 0; i < 5; i++) push_sample(24'($urandom()));
    chk_irq("irq_ovf");
    acc("status_ovf", 1'b0, 32'h4, 32'h0, 1'b0, 24'h0, rd);
    chk("status_ovf_const", rd, 32'h1042);
    acc("clr_ovf", 1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0, 24'h0, rd);
    chk_irq("irq_ovf_clr");
    acc("status_full", 1'b0, 32'h4, 32'h0, 1'b0, 24'h0, rd);

    // Full FIFO: pop and push on the same edge
    nv = 24'($urandom());
    acc("pop_push_full", 1'b0, 32'h8, 32'h0, 1'b1, nv, rd);
    acc("status_pp", 1'b0, 32'h4, 32'h0, 1'b0, 24'h0, rd);
    chk("status_pp_const", rd, 32'h42);
    for (int i = 0; i < 4; i++) acc("drain", 1'b0, 32'h8, 32'h0, 1'b0, 24'h0, rd);
    chk("last_is_new", rd, {8'h00, nv});

    // Error responses without side effects
    push_sample(24'hA5A5A5);
    acc("err_wr_data", 1'b1, 32'h8, 32'hFFFF_FFFF, 1'b0, 24'h0, rd);
    acc("err_rd_0x10", 1'b0, 32'h10, 32'h0, 1'b0, 24'h0, rd);
    acc("err_rd_0x100", 1'b0, 32'h100, 32'h0, 1'b0, 24'h0, rd);
    acc("err_wr_0x100", 1'b1, 32'h100, 32'h7, 1'b0, 24'h0, rd);
    acc("status_after_err", 1'b0, 32'h4, 32'h0, 1'b0, 24'h0, rd);
    acc("ctrl_after_err", 1'b0, 32'h0, 32'h0, 1'b0, 24'h0, rd);

    // Randomized operations against the model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1: push_sample(24'($urandom()));
        2: acc("rnd_data", 1'b0, 32'h8, 32'h0, 1'($urandom_range(0, 1)), 24'($urandom()), rd);
        3: acc("rnd_status", 1'b0, 32'h4, 32'h0, 1'($urandom_range(0, 1)), 24'($urandom()), rd);
        4: acc("rnd_thresh", 1'b1, 32'hC, 32'($urandom_range(0, 31)), 1'b0, 24'h0, rd);
        5: acc("rnd_ctrl", 1'b1, 32'h0,
               {29'h0, 1'($urandom_range(0, 3) == 0), 1'b1, 1'($urandom_range(0, 4) != 0)},
               1'($urandom_range(0, 1)), 24'($urandom()), rd);
        6: acc("rnd_wstatus", 1'b1, 32'h4, $urandom(), 1'b0, 24'h0, rd);
        default: acc("rnd_rthresh", 1'b0, 32'hC, 32'h0, 1'b0, 24'h0, rd);
      endcase
      chk_irq("rnd_irq");
    end

    // Reset asserted in the middle of an access phase
    acc("pre_rst_ctrl", 1'b1, 32'h0, 32'h3, 1'b0, 24'h0, rd);
    acc("pre_rst_clr", 1'b1, 32'h0, 32'h7, 1'b0, 24'h0, rd);
    for (int i = 0; i < 3; i++) push_sample(24'($urandom()));
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'hC; bus.pwdata = 32'h3;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_pready", {31'h0, bus.pready}, 32'h0);
    chk("mid_rst_prdata", bus.prdata, 32'h0);
    chk("mid_rst_pslverr", {31'h0, bus.pslverr}, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    chk("mid_rst_sensor_en", {31'h0, sensor_en}, 32'h0);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    acc("post_rst_status", 1'b0, 32'h4, 32'h0, 1'b0, 24'h0, rd);
    chk("post_rst_status_const", rd, 32'h1);
    acc("post_rst_ctrl", 1'b0, 32'h0, 32'h0, 1'b0, 24'h0, rd);
    acc("post_rst_thresh", 1'b0, 32'hC, 32'h0, 1'b0, 24'h0, rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
